// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// the maximum requester count and the round-robin pick function.
package dmem_arb_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int NREQ_MAX = 4;
  localparam int PTR_W    = 2;

  // Returns a one-hot grant. The search starts at last+1 and wraps modulo n,
  // so the most recently served port has the lowest priority.
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] req,
    input logic [PTR_W-1:0]    last,
    input logic [2:0]          n
  );
    logic [NREQ_MAX-1:0] pick;
    logic [3:0]          idx;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      idx = {2'b00, last} + 4'(k);
      if (idx >= {1'b0, n}) idx = idx - {1'b0, n};
      if (!found && (4'(k) <= {1'b0, n}) && req[idx[1:0]]) begin
        pick[idx[1:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own last-granted pointer. Grant is
// combinational; the pointer advances to the winner on every grant.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_any
);

  logic [PTR_W-1:0]    last_q;
  logic [PTR_W-1:0]    last_d;
  logic [NREQ_MAX-1:0] req_ext;
  logic [NREQ_MAX-1:0] pick;

  // Widen the request vector to the package's maximum port count.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  assign pick    = rr_pick(req_ext, last_q, 3'(NREQ));
  assign gnt     = pick[NREQ-1:0];
  assign gnt_any = |pick;

  // Next pointer: index of the winner, or hold when nobody is granted.
  always_comb begin
    last_d = last_q;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (pick[i]) last_d = PTR_W'(i);
    end
  end

  // Pointer register; reset value makes port 0 the first winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= PTR_W'(NREQ - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between NREQ requesters with
// round-robin arbitration and a registered read-response stage.
// Optional misaligned-access checking: define DMEM_ARB_ALIGN_CHK_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2,       // legal 2..4
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    err,
  output logic               mem_we,
  output logic [AW-1:0]      mem_a,
  output logic [DW-1:0]      mem_wd,
  input  logic [DW-1:0]      mem_rd
);

  logic [NREQ-1:0] req_v;
  logic            gnt_any;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wd;
  logic            misalign;
  logic            load_gnt;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  // Requests are masked while in reset so grant and memory drive stay idle.
  assign req_v = req & {NREQ{reset_n}};

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_v),
    .gnt     (gnt),
    .gnt_any (gnt_any)
  );

  // One-hot OR mux of the granted port's fields; all zero with no grant.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we   = sel_we   | req_we[i];
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_wd   = sel_wd   | req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  // A misaligned grant still uses the slot but must not touch memory.
  assign misalign = gnt_any & (sel_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_we   = gnt_any & sel_we & ~misalign;
  assign mem_a    = sel_addr;
  assign mem_wd   = sel_wd;
  assign load_gnt = gnt_any & ~sel_we & ~misalign;

  // Response next-state: a load returns to its port next cycle; rdata only
  // changes on a new load grant.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (load_gnt) begin
      rvalid_d = gnt;
      rdata_d  = mem_rd;
    end
  end

  // Response stage register; reset discards any in-flight response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic [NREQ-1:0] err_q, err_d;

  // Error pulse is aligned with where rvalid would have appeared.
  always_comb begin
    err_d = '0;
    if (misalign) err_d = gnt;
  end

  // Error register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a behavioural model.
module tb_dmem_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b0;
  logic [NREQ-1:0]    req       = '0;
  logic [NREQ-1:0]    req_we    = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, rvalid, err;
  logic [DW-1:0]      rdata, mem_wd, mem_rd;
  logic               mem_we;
  logic [AW-1:0]      mem_a;

  dmem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory the DUT drives, and the model's own view of its contents.
  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    int          port;
    bit          is_err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] exp_rdata = '0;
  int            ptr       = NREQ - 1;
  bit            pend [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model of one arbitration cycle: pick the winner by plain
  // round-robin search, check the combinational outputs, record effects.
  task automatic model_check();
    int            win;
    int            idx;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    bit            we, mis;
    resp_t         e;
    win = -1;
    if (reset_n) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (win < 0 && req[idx]) win = idx;
      end
    end
    if (win < 0) begin
      check("gnt", gnt, 0);
      check("mem_we_idle", mem_we, 0);
      check("mem_a_idle", mem_a, 0);
      check("mem_wd_idle", mem_wd, 0);
    end else begin
      ad  = req_addr[win*AW +: AW];
      wd  = req_wdata[win*DW +: DW];
      we  = req_we[win];
      mis = ALIGN && (ad[1:0] != 2'b00);
      check("gnt", gnt, 64'(1) << win);
      check("mem_we", mem_we, we && !mis);
      check("mem_a", mem_a, ad);
      check("mem_wd", mem_wd, wd);
      ptr = win;
      e.cyc  = cyc + 1;
      e.port = win;
      if (mis) begin
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
      end else if (we) begin
        ref_mem[ad[7:2]] = wd;
      end else begin
        e.is_err = 1'b0;
        e.data   = ref_mem[ad[7:2]];
        exp_q.push_back(e);
      end
    end
  endtask

  // One cycle: called at posedge+1 with inputs set, returns at next posedge+1.
  task automatic tick(output logic [NREQ-1:0] g);
    #3;
    model_check();
    g = gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]                 = r;
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NREQ; p++) set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rdata = '0;
    ptr       = NREQ - 1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rvalid != '0 || err != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {rvalid, err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          if (e.is_err) begin
            check("err", err, 64'(1) << e.port);
            check("rvalid_on_err", rvalid, 0);
          end else begin
            check("rvalid", rvalid, 64'(1) << e.port);
            check("err_on_load", err, 0);
            check("rdata", rdata, e.data);
            exp_rdata = e.data;
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_resp", {rvalid, err},
              e.is_err ? (64'(1) << e.port) : (64'(1) << (e.port + NREQ)));
      end
      check("rdata_hold", rdata, exp_rdata);
    end
  end

  // Stimulus.
  initial begin
    logic [NREQ-1:0] g;
    logic [7:0]      a8;
    int              bad;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = mem[i];
    end
    mem[3]     = 32'hCAFE_BABE;
    ref_mem[3] = 32'hCAFE_BABE;

    // Reset state, with requests pending that must not be granted.
    @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    set_port(0, 1'b1, 1'b1, 32'h4, 32'h1111_1111);
    set_port(1, 1'b1, 1'b1, 32'h8, 32'h2222_2222);
    tick(g);
    check("rst_gnt", g, 0);
    clear_ports();
    reset_n = 1'b1;

    // Single load after reset.
    set_port(0, 1'b1, 1'b0, 32'h0C, '0);
    tick(g);
    check("A_gnt", g, 2'b01);
    clear_ports();
    check("A_rvalid", rvalid, 2'b01);
    check("A_rdata", rdata, 32'hCAFE_BABE);
    tick(g);

    // Reset again, then continuous contention.
    reset_n = 1'b0;
    model_reset();
    tick(g);
    tick(g);
    reset_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h0C, '0);
    set_port(1, 1'b1, 1'b0, 32'h14, '0);
    for (int i = 0; i < 6; i++) begin
      tick(g);
      check("C_gnt", g, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    clear_ports();
    tick(g);

    // Store then load on the same port.
    set_port(1, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
    tick(g);
    check("D_gnt_st", g, 2'b10);
    set_port(1, 1'b1, 1'b0, 32'h10, '0);
    tick(g);
    check("D_gnt_ld", g, 2'b10);
    clear_ports();
    check("D_rdata", rdata, 32'h1234_5678);
    tick(g);

    // Lone repeated requester gets back-to-back grants.
    set_port(1, 1'b1, 1'b0, 32'h0C, '0);
    for (int i = 0; i < 3; i++) begin
      tick(g);
      check("E_gnt", g, 2'b10);
      check("E_rvalid", rvalid, 2'b10);
    end
    clear_ports();
    tick(g);

    // Misaligned store.
    set_port(0, 1'b1, 1'b1, 32'h0E, 32'hFFFF_FFFF);
    tick(g);
    check("F_gnt", g, 2'b01);
    clear_ports();
    check("F_err", err, ALIGN ? 2'b01 : 2'b00);
    tick(g);
    check("F_word3", mem[3], ALIGN ? 32'hCAFE_BABE : 32'hFFFF_FFFF);

    // Reset while a load response is in flight.
    set_port(0, 1'b1, 1'b0, 32'h10, '0);
    tick(g);
    set_port(1, 1'b1, 1'b0, 32'h20, '0);
    reset_n = 1'b0;
    model_reset();
    tick(g);
    check("G_rvalid", rvalid, 0);
    check("G_rdata", rdata, 0);
    reset_n = 1'b1;
    tick(g);
    check("G_first", g, 2'b01);
    clear_ports();
    tick(g);
    tick(g);

    // Randomized traffic with hold-until-granted and occasional drops.
    for (int p = 0; p < NREQ; p++) pend[p] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NREQ; p++) begin
        if (pend[p] && $urandom_range(0, 15) == 0) begin
          pend[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, '0, '0);
        end
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          a8 = 8'($urandom_range(0, 63)) << 2;
          if ($urandom_range(0, 7) == 0) a8[1:0] = 2'($urandom_range(1, 3));
          pend[p] = 1'b1;
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), {24'h0, a8}, $urandom);
        end
      end
      tick(g);
      for (int p = 0; p < NREQ; p++) begin
        if (g[p]) begin
          pend[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    clear_ports();
    tick(g);
    tick(g);
    tick(g);

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_final", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
